// File: rtl/mul_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mul_div_unit: multi-cycle MIPS multiply/divide unit owning HI/LO.   |
// | Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU accumulate ops.     |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module mul_div_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_sel,
  output logic        busy,
  output logic [31:0] result
);

  localparam logic [3:0] c_OP_MULT  = 4'd0;
  localparam logic [3:0] c_OP_MULTU = 4'd1;
  localparam logic [3:0] c_OP_DIV   = 4'd2;
  localparam logic [3:0] c_OP_DIVU  = 4'd3;
  localparam logic [3:0] c_OP_MTHI  = 4'd4;
  localparam logic [3:0] c_OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
  localparam logic [3:0] c_OP_MADD  = 4'd6;
  localparam logic [3:0] c_OP_MADDU = 4'd7;
  localparam logic [3:0] c_OP_MSUB  = 4'd8;
  localparam logic [3:0] c_OP_MSUBU = 4'd9;
`endif
  localparam logic [7:0] c_MUL_CNT  = 8'(MUL_CYCLES);
  localparam logic [7:0] c_DIV_CNT  = 8'(DIV_CYCLES);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt;
  logic [31:0] r_hi, r_lo, r_a, r_b;
  logic [3:0]  r_op;

  logic        w_multi, w_is_div, w_launch, w_done, w_wr;
  logic [63:0] w_prod_s, w_prod_u, w_pend;
  logic [31:0] w_quo_s, w_rem_s;

  always_comb begin
    w_multi = 1'b0;
    case (op)
      c_OP_MULT, c_OP_MULTU, c_OP_DIV, c_OP_DIVU: w_multi = 1'b1;
`ifdef MDU_MADD_EN
      c_OP_MADD, c_OP_MADDU, c_OP_MSUB, c_OP_MSUBU: w_multi = 1'b1;
`endif
      default: w_multi = 1'b0;
    endcase
  end

  assign w_is_div = (op == c_OP_DIV) || (op == c_OP_DIVU);
  assign w_launch = (r_state == S_IDLE) && start && w_multi;
  assign w_done   = (r_state == S_RUN) && (r_cnt == 8'd1);
  assign busy     = (r_state == S_RUN);
  assign result   = rd_sel ? r_lo : r_hi;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == 8'd1) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sign-extend both operands so the 64-bit product is the full signed result.
  assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // INT_MIN / -1 overflows 32 bits; pin it to the architectural answer.
  always_comb begin
    if (r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF) begin
      w_quo_s = r_a;
      w_rem_s = 32'd0;
    end else begin
      w_quo_s = $signed(r_a) / $signed(r_b);
      w_rem_s = $signed(r_a) % $signed(r_b);
    end
  end

  always_comb begin
    w_pend = {r_hi, r_lo};
    w_wr   = 1'b1;
    case (r_op)
      c_OP_MULT:  w_pend = w_prod_s;
      c_OP_MULTU: w_pend = w_prod_u;
      c_OP_DIV: begin
        w_wr   = (r_b != 32'd0);
        w_pend = {w_rem_s, w_quo_s};
      end
      c_OP_DIVU: begin
        w_wr   = (r_b != 32'd0);
        w_pend = {r_a % r_b, r_a / r_b};
      end
`ifdef MDU_MADD_EN
      c_OP_MADD:  w_pend = {r_hi, r_lo} + w_prod_s;
      c_OP_MADDU: w_pend = {r_hi, r_lo} + w_prod_u;
      c_OP_MSUB:  w_pend = {r_hi, r_lo} - w_prod_s;
      c_OP_MSUBU: w_pend = {r_hi, r_lo} - w_prod_u;
`endif
      default:    w_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 8'd0;
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
      r_op  <= 4'd0;
      r_a   <= 32'd0;
      r_b   <= 32'd0;
    end else begin
      if (w_launch) begin
        r_op  <= op;
        r_a   <= a;
        r_b   <= b;
        r_cnt <= w_is_div ? c_DIV_CNT : c_MUL_CNT;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt - 8'd1;
      end

      if (w_done && w_wr) begin
        {r_hi, r_lo} <= w_pend;
      end else if (r_state == S_IDLE && start && op == c_OP_MTHI) begin
        r_hi <= a;
      end else if (r_state == S_IDLE && start && op == c_OP_MTLO) begin
        r_lo <= a;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mul_div_unit: random and directed checks of mul_div_unit.        |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_mul_div_unit;
  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        rd_sel = 1'b0;
  logic        busy;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mul_div_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .rd_sel(rd_sel), .busy(busy), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int exp_cycles(input logic [3:0] o);
    case (o)
      4'd0, 4'd1: return MUL_N;
      4'd2, 4'd3: return DIV_N;
`ifdef MDU_MADD_EN
      4'd6, 4'd7, 4'd8, 4'd9: return MUL_N;
`endif
      default: return 0;
    endcase
  endfunction

  // Architectural effect of one op on the HI/LO model.
  task automatic model_exec(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy;
    logic [63:0] ps, pu, acc;
    int          ix, iy;
    sx  = longint'(signed'(x));
    sy  = longint'(signed'(y));
    ps  = 64'(sx * sy);
    pu  = {32'd0, x} * {32'd0, y};
    acc = {m_hi, m_lo};
    ix  = x;
    iy  = y;
    case (o)
      4'd0: {m_hi, m_lo} = ps;
      4'd1: {m_hi, m_lo} = pu;
      4'd2: if (y != 0) begin
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          m_lo = x; m_hi = 32'd0;
        end else begin
          m_lo = 32'(ix / iy); m_hi = 32'(ix % iy);
        end
      end
      4'd3: if (y != 0) begin
        m_lo = x / y; m_hi = x % y;
      end
      4'd4: m_hi = x;
      4'd5: m_lo = x;
`ifdef MDU_MADD_EN
      4'd6: {m_hi, m_lo} = acc + ps;
      4'd7: {m_hi, m_lo} = acc + pu;
      4'd8: {m_hi, m_lo} = acc - ps;
      4'd9: {m_hi, m_lo} = acc - pu;
`endif
      default: ;
    endcase
  endtask

  task automatic read_check(input string tag);
    rd_sel = 1'b0; #1;
    check({tag, "_hi"}, result, m_hi);
    rd_sel = 1'b1; #1;
    check({tag, "_lo"}, result, m_lo);
  endtask

  // Called at a negedge; launches at the next posedge and waits for completion.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input string tag);
    int cnt;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
    cnt = 0;
    while (busy === 1'b1 && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, "_busy"}, 32'(cnt), 32'(exp_cycles(o)));
    model_exec(o, x, y);
    read_check(tag);
  endtask

  initial begin
    int cnt;
    logic [3:0]  ro;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    read_check("rst");

    run_op(4'd0, 32'hFFFF_FFFE, 32'h0000_0003, "mult");
    run_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu");
    run_op(4'd2, 32'hFFFF_FFF9, 32'h0000_0002, "div");
    run_op(4'd3, 32'h0000_0007, 32'h0000_0000, "divu0");
    run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(4'd2, 32'h0000_0011, 32'h0000_0000, "div0");
    run_op(4'd4, 32'h1234_5678, 32'h0, "mthi");
    run_op(4'd12, 32'hCAFE_F00D, 32'h1, "noop");

    // MTLO issued mid-RUN must be ignored.
    start = 1'b1; op = 4'd0; a = 32'd7; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 4'd5; a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    cnt = 2;
    while (busy === 1'b1 && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    check("midrun_busy", 32'(cnt), 32'(MUL_N));
    model_exec(4'd0, 32'd7, 32'd9);
    read_check("midrun");

    // Reset on the 4th busy cycle of a DIV.
    start = 1'b1; op = 4'd2; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    read_check("midrst");
    repeat (12) @(negedge clk);
    check("midrst_late_busy", {31'd0, busy}, 32'd0);
    read_check("midrst_late");

    // Accumulate (no-op when the feature is absent).
    run_op(4'd4, 32'h0000_0000, 32'h0, "acc_mthi");
    run_op(4'd5, 32'hFFFF_FFFF, 32'h0, "acc_mtlo");
    run_op(4'd7, 32'h0000_0001, 32'h1, "maddu");
    run_op(4'd8, 32'h0000_0003, 32'hFFFF_FFFE, "msub");

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 16));
        default: rb = 32'($urandom);
      endcase
      run_op(ro, ra, rb, $sformatf("rnd%0d_op%0d", i, ro));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
